// File: rtl/vec_sequencer.sv
// Replays up to Depth stored stimulus vectors into the fuzz datapath and folds each response
// into a MISR signature. Define SEQ_GOLDEN_EN to add a golden-signature compare (pass_o).
module vec_sequencer #(
  parameter int unsigned    VecW    = 79,
  parameter int unsigned    YW      = 646,
  parameter int unsigned    Depth   = 16,
  parameter int unsigned    HoldCyc = 2,
  parameter int unsigned    SigW    = 32,
  parameter logic [SigW-1:0] Poly   = 32'h04C11DB7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [VecW-1:0]          wr_data_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cap_valid_o,
  output logic [$clog2(Depth):0]   vec_count_o,
  output logic [VecW-1:0]          dut_in_o,
  input  logic [YW-1:0]            dut_y_i,
`ifdef SEQ_GOLDEN_EN
  input  logic [SigW-1:0]          golden_sig_i,
  output logic                     pass_o,
`endif
  output logic [SigW-1:0]          signature_o
);

  localparam int unsigned IdxW   = $clog2(Depth);
  localparam int unsigned CntW   = IdxW + 1;
  localparam int unsigned HoldW  = (HoldCyc > 1) ? $clog2(HoldCyc) : 1;
  localparam int unsigned NSlice = (YW + SigW - 1) / SigW;

  typedef enum logic [2:0] {StIdle, StApply, StHold, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [VecW-1:0]   dut_in_q, dut_in_d;
  logic [SigW-1:0]   sig_q, sig_d;
  logic [VecW-1:0]   vec_buf_q [Depth];
  logic              wr_en;

  logic [NSlice*SigW-1:0] y_pad;
  logic [SigW-1:0]        fold;

  // Top slice is zero-extended by the padding before the XOR reduction.
  always_comb begin
    y_pad = '0;
    y_pad[YW-1:0] = dut_y_i;
    fold = '0;
    for (int unsigned i = 0; i < NSlice; i++) begin
      fold = fold ^ y_pad[i*SigW +: SigW];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    dut_in_d    = dut_in_q;
    sig_d       = sig_q;
    wr_ready_o  = 1'b0;
    wr_en       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    cap_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_ready_o = ~rst_i & (cnt_q < CntW'(Depth)) & ~start_i & ~clear_i;
        wr_en      = wr_valid_i & wr_ready_o;
        if (clear_i) begin
          cnt_d = '0;
        end else if (start_i) begin
          sig_d   = '0;
          idx_d   = '0;
          state_d = (cnt_q != '0) ? StApply : StDone;
        end else if (wr_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StApply: begin
        busy_o   = 1'b1;
        dut_in_d = vec_buf_q[idx_q];
        hold_d   = HoldW'(HoldCyc - 1);
        state_d  = StHold;
      end
      StHold: begin
        busy_o = 1'b1;
        if (hold_q == '0) begin
          state_d = StCapture;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      StCapture: begin
        busy_o      = 1'b1;
        cap_valid_o = 1'b1;
        sig_d = {sig_q[SigW-2:0], 1'b0} ^ (sig_q[SigW-1] ? Poly : '0) ^ fold;
        if (CntW'(idx_q) == cnt_q - 1'b1) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StApply;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      dut_in_q <= '0;
      sig_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      dut_in_q <= dut_in_d;
      sig_q    <= sig_d;
    end
  end

  // Buffer contents are not reset; only vec_count defines what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      vec_buf_q[cnt_q[IdxW-1:0]] <= wr_data_i;
    end
  end

  assign vec_count_o = cnt_q;
  assign dut_in_o    = dut_in_q;
  assign signature_o = sig_q;

`ifdef SEQ_GOLDEN_EN
  logic pass_q, pass_d;

  always_comb begin
    pass_d = pass_q;
    if (state_q == StDone) begin
      pass_d = (sig_q == golden_sig_i);
    end else if (state_q == StIdle && start_i && !clear_i) begin
      pass_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass_o = pass_q;
`endif

endmodule

// File: tb/tb_vec_sequencer.sv
// Directed bench for vec_sequencer: table of replay runs with hand-computed MISR results,
// plus reset-abort, full-buffer and same-cycle control corner cases.
module tb_vec_sequencer;

  localparam int unsigned VecW    = 79;
  localparam int unsigned YW      = 646;
  localparam int unsigned Depth   = 16;
  localparam int unsigned HoldCyc = 2;
  localparam int unsigned SigW    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [VecW-1:0]   wr_data = '0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              cap_valid;
  logic [4:0]        vec_count;
  logic [VecW-1:0]   dut_in;
  logic [YW-1:0]     dut_y = '0;
  logic [SigW-1:0]   signature;
`ifdef SEQ_GOLDEN_EN
  logic [SigW-1:0]   golden_sig = '0;
  logic              pass;
`endif

  always #5 clk = ~clk;

  vec_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_data_i    (wr_data),
    .clear_i      (clear),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .cap_valid_o  (cap_valid),
    .vec_count_o  (vec_count),
    .dut_in_o     (dut_in),
    .dut_y_i      (dut_y),
`ifdef SEQ_GOLDEN_EN
    .golden_sig_i (golden_sig),
    .pass_o       (pass),
`endif
    .signature_o  (signature)
  );

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int unsigned     n;
    logic [YW-1:0]   y;
    logic [SigW-1:0] sig;
  } case_t;

  case_t cases [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [VecW-1:0] vec_of(input int unsigned i, input int unsigned base);
    logic [VecW-1:0] v;
    v[78:64] = 15'(i + 1);
    v[63:0]  = 64'(base) * 64'h0000_0001_0000_0001 + 64'h0123_4567_89AB_CDEF * 64'(i + 1);
    return v;
  endfunction

  task automatic clear_buf();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load(input int unsigned n, input int unsigned base);
    for (int unsigned i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = vec_of(i, base);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic run(input int unsigned n, input logic [YW-1:0] y, input logic [SigW-1:0] exp_sig,
                     input int unsigned base, input int tag);
    int unsigned cyc;
    int unsigned caps;
    bit          seen;
    dut_y = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc  = 1;
    caps = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      if (cap_valid) begin
        check($sformatf("r%0d_dut_in_%0d", tag, caps), dut_in, vec_of(caps, base));
        caps++;
      end
      if (done) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    check($sformatf("r%0d_done_seen", tag), seen, 1);
    check($sformatf("r%0d_latency", tag), cyc, n * (HoldCyc + 2) + 1);
    check($sformatf("r%0d_caps", tag), caps, n);
    check($sformatf("r%0d_sig", tag), signature, exp_sig);
    check($sformatf("r%0d_busy_in_done", tag), busy, 0);
    tick();
    check($sformatf("r%0d_done_pulse", tag), done, 0);
    if (n > 0) check($sformatf("r%0d_dut_in_hold", tag), dut_in, vec_of(n - 1, base));
  endtask

  initial begin
    bit seen;

    cases[0].n = 0; cases[0].y = '0; cases[0].y[0] = 1'b1; cases[0].sig = 32'h0000_0000;
    cases[1].n = 1; cases[1].y = '0; cases[1].y[0] = 1'b1; cases[1].sig = 32'h0000_0001;
    cases[2].n = 2; cases[2].y = '0; cases[2].y[0] = 1'b1; cases[2].sig = 32'h0000_0003;
    cases[3].n = 3; cases[3].y = '0; cases[3].y[0] = 1'b1; cases[3].sig = 32'h0000_0007;
    // Slices 20 (zero-extended), 1 and 0 all contribute: 0x20 ^ 0x1 ^ 0x8.
    cases[4].n = 1; cases[4].y = '0; cases[4].y[645] = 1'b1; cases[4].y[32] = 1'b1;
    cases[4].y[3] = 1'b1; cases[4].sig = 32'h0000_0029;
    // Second capture shifts out the MSB and applies the feedback polynomial.
    cases[5].n = 2; cases[5].y = '0; cases[5].y[31] = 1'b1; cases[5].sig = 32'h84C1_1DB7;
    cases[6].n = 1; cases[6].y = '0; cases[6].y[63:0] = 64'hFFFF_FFFF_0000_0001;
    cases[6].sig = 32'hFFFF_FFFE;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cap_valid", cap_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_signature", signature, 0);
    rst = 1'b0;
    tick();
    check("idle_wr_ready", wr_ready, 1);

    // Table-driven replay runs
    for (int k = 0; k < 7; k++) begin
      clear_buf();
      load(cases[k].n, k + 1);
      check($sformatf("c%0d_vec_count", k), vec_count, cases[k].n);
      run(cases[k].n, cases[k].y, cases[k].sig, k + 1, k);
    end

    // Reset during the second vector's hold aborts with no done pulse
    clear_buf();
    load(3, 50);
    dut_y = '0;
    dut_y[0] = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_before", busy, 1);
    check("mid_sig_before", signature, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dut_in", dut_in, 0);
    check("mid_rst_sig", signature, 0);
    check("mid_rst_vec_count", vec_count, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | done | busy;
      tick();
    end
    check("mid_rst_no_done", seen, 0);

    // Full buffer: 17 writes with wr_valid held, 16 accepted in order
    clear_buf();
    wr_valid = 1'b1;
    for (int unsigned i = 0; i < 17; i++) begin
      wr_data = vec_of(i, 99);
      tick();
      if (i == 0) check("full_count_first", vec_count, 1);
      if (i == 15) begin
        check("full_wr_ready", wr_ready, 0);
        check("full_count_16", vec_count, 16);
      end
    end
    wr_valid = 1'b0;
    check("full_count_sat", vec_count, 16);
    dut_y = '0;
    dut_y[0] = 1'b1;
    run(16, dut_y, 32'h0000_FFFF, 99, 20);
    run(16, dut_y, 32'h0000_FFFF, 99, 21);

    // clear and start together: clear wins, no replay
    clear_buf();
    load(2, 60);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("cs_vec_count", vec_count, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | done | busy;
      tick();
    end
    check("cs_no_replay", seen, 0);

    // wr_valid alongside start is not accepted
    load(1, 70);
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = vec_of(5, 70);
    #1;
    check("ws_wr_ready", wr_ready, 0);
    tick();
    start    = 1'b0;
    wr_valid = 1'b0;
    check("ws_busy", busy, 1);
    for (int i = 0; i < 20 && !done; i++) tick();
    check("ws_done", done, 1);
    check("ws_vec_count", vec_count, 1);
    tick();

`ifdef SEQ_GOLDEN_EN
    clear_buf();
    load(1, 80);
    dut_y = '0;
    dut_y[0] = 1'b1;
    golden_sig = 32'h0000_0001;
    run(1, dut_y, 32'h0000_0001, 80, 30);
    check("golden_pass", pass, 1);
    golden_sig = 32'h0000_0002;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("golden_start_clears", pass, 0);
    for (int i = 0; i < 20 && !done; i++) tick();
    tick();
    check("golden_fail", pass, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vec_sequencer.md
Name: vec_sequencer

Overview:
- Sequences the fuzz-generated `top` datapath for self-checking runs.
- Host loads up to DEPTH stimulus vectors into an internal buffer; on `start` the block replays them in order on `dut_in`, which drives {wire3, wire2, wire1, wire0}.
- Each vector is held for HOLD_CYC cycles, then the 646-bit `dut_y` is sampled and compressed into a 32-bit signature (MISR).
- Replaces the open-loop stimulus/strobe pattern with a deterministic, comparable result.

Parameters:
- VEC_W, 79, stimulus width; concatenation {wire3[15:0], wire2[21:0], wire1[19:0], wire0[20:0]}.
- Y_W, 646, DUT output width.
- DEPTH, 16, vector buffer entries; must be a power of 2.
- HOLD_CYC, 2, cycles each vector is held before capture; minimum 1.
- SIG_W, 32, signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_valid  in  1  host vector write request.
- wr_ready  out  1  buffer accepts a write this cycle.
- wr_data  in  VEC_W  vector to append.
- clear  in  1  empties the buffer; honoured in IDLE only.
- start  in  1  begin replay; honoured in IDLE only.
- busy  out  1  high in APPLY/HOLD/CAPTURE.
- done  out  1  one-cycle pulse when replay ends.
- cap_valid  out  1  one-cycle pulse per captured vector.
- vec_count  out  $clog2(DEPTH)+1  number of vectors stored.
- dut_in  out  VEC_W  registered stimulus to DUT.
- dut_y  in  Y_W  DUT output.
- signature  out  SIG_W  running MISR value.

Behaviour:
- Reset (synchronous, rst=1 at posedge) clears every output to 0: dut_in=0, signature=0, vec_count=0, busy=0, done=0, cap_valid=0, wr_ready=0. State goes to IDLE. Buffer contents are don't-care.
- rst mid-replay aborts immediately with the same values; no done pulse.
- States: IDLE, APPLY, HOLD, CAPTURE, DONE.
- IDLE:
  - wr_ready = (vec_count < DEPTH) & ~start & ~clear.
  - A write handshake (wr_valid & wr_ready) stores wr_data at index vec_count and increments vec_count.
  - When full, wr_ready=0 and writes are dropped; vec_count saturates at DEPTH.
  - clear sets vec_count=0 next cycle. clear has priority over start.
  - start with vec_count>0: signature<=0, idx<=0, go to APPLY.
  - start with vec_count==0: go to DONE with signature=0.
- APPLY (1 cycle): dut_in <= buf[idx]; hold counter <= HOLD_CYC-1; go to HOLD.
- HOLD: counts down HOLD_CYC cycles with dut_in stable; at 0 go to CAPTURE.
- CAPTURE (1 cycle):
  - fold = XOR of all SIG_W-bit slices of dut_y, with the top slice zero-extended.
  - signature <= ((signature<<1) ^ (signature[SIG_W-1] ? POLY : 0)) ^ fold.
  - cap_valid=1 this cycle.
  - If idx==vec_count-1, go to DONE; else idx++ and go to APPLY.
- DONE (1 cycle): done=1, then IDLE.
- Per-vector latency is 1+HOLD_CYC+1 cycles. A run of N vectors raises done N*(HOLD_CYC+2)+1 cycles after start is sampled.
- start, clear and wr_valid outside IDLE are ignored; wr_ready=0 outside IDLE.
- After a run, dut_in and signature hold their final values.
- The buffer is retained after a run, so a second start replays the same vectors.

Optional Feature:
- Macro: SEQ_GOLDEN_EN.
- Defined:
  - Adds port golden_sig (in, SIG_W) and port pass (out, 1, reset 0).
  - In DONE, pass <= (signature == golden_sig); pass holds until the next start or rst.
  - start clears pass.
- Undefined: neither port exists and no compare logic is built.

Test Plan:
- Reset mid-replay: 3 vectors loaded, start, assert rst during HOLD -> next cycle busy=0, dut_in=0, signature=0, vec_count=0, and no done pulse.
- Single vector: load 79'h1, dut_y tied to 646'h1, HOLD_CYC=2, start -> dut_in=79'h1 one cycle after start; cap_valid 3 cycles later; signature=32'h00000001; done pulse at cycle 5 after start.
- Two vectors with dut_y=646'h1 for both captures -> signature after the second capture = (1<<1)^1 = 32'h00000003; exactly 2 cap_valid pulses.
- Full buffer: 17 writes with wr_valid held -> 16 accepted, wr_ready=0 after the 16th, vec_count=16; start then replays 16 vectors in write order, checked on dut_in.
- Boundary events: start with vec_count=0 -> done 1 cycle later, signature=0; clear and start in the same cycle -> vec_count=0, no replay; wr_valid with start in the same cycle -> write not accepted.
- SEQ_GOLDEN_EN: single-vector case with golden_sig=32'h00000001 -> pass=1 after done; rerun with golden_sig=32'h00000002 -> pass=0.
